mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter between the execute unit's memory port and a DMA/debug master, sharing one downstream memory port. It decodes the core's fetch, read and write requests, arbitrates round-robin against the DMA port, and drives a single req/ack bus. It returns per-type done pulses to the core and an ack to DMA. An optional watchdog aborts accesses that hang.

## Interface
- RV, 16: data width; must be 16 or 32.
- VA, RV: virtual address width.
- TIMEOUT, 255: watchdog limit in cycles; used only with `MEM_TIMEOUT_EN`.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- ifetch  in  1  core instruction-fetch request (level).
- rstrobe  in  2  core read byte-lane strobes; nonzero means a read request (level).
- wmask  in  RV/8  core write byte mask; nonzero means a write request (level).
- io_access  in  1  core access targets I/O space.
- addr  in  VA-RV/16  core word address.
- wdata  in  RV  core write data.
- idone, rdone, wdone  out  1 each  one-cycle completion pulses to the core.
- rdata  out  RV  read data; valid while idone or rdone is high.
- dma_req  in  1  DMA request (level).
- dma_we  in  1  DMA write.
- dma_addr  in  VA-RV/16  DMA word address.
- dma_wdata  in  RV  DMA write data.
- dma_wmask  in  RV/8  DMA byte mask.
- dma_ack  out  1  one-cycle DMA completion pulse; rdata is valid with it.
- mem_req  out  1  downstream request.
- mem_we  out  1  downstream write.
- mem_io  out  1  downstream I/O qualifier.
- mem_addr  out  VA-RV/16  downstream word address.
- mem_wdata  out  RV  downstream write data.
- mem_wmask  out  RV/8  downstream byte mask.
- mem_ack  in  1  downstream completion; mem_rdata is valid with it.
- mem_rdata  in  RV  downstream read data.
- bus_err  out  1  one-cycle pulse when an access is aborted by the watchdog.

## Operation
- Requesters hold their request level until their completion pulse. The core asserts at most one of ifetch, |rstrobe, |wmask at a time. Priority when several are high (protocol error): ifetch > read > write.
- FSM states:
  - IDLE: sample requests.
  - BUSY: downstream access outstanding.
  - DONE: completion pulses asserted.
- IDLE → BUSY when any request is pending.
  - Winner selection: if only one requester is pending, it wins. If both are pending, the requester not granted last wins (round-robin bit `last`).
  - On entry to BUSY: latch owner, kind (fetch/read/write), address, data, mask and io into the mem_* registers.
  - Core read or fetch: mem_wmask = 0, mem_io = io_access; fetch forces mem_io = 0.
  - DMA: mem_io = 0.
- BUSY → DONE on mem_ack. Capture mem_rdata into rdata (write: rdata unchanged). Drop mem_req.
- DONE → IDLE unconditionally. In DONE, exactly one of idone/rdone/wdone/dma_ack is high, selected by the latched owner and kind. `last` updates to the owner.
- A new request is evaluated only in IDLE. A request still high in DONE is therefore never double-granted; requesters drop their level by the cycle after the pulse.
- All mem_* outputs are registered and stable throughout BUSY.

## Timing
- Reset values: mem_req = 0, mem_we = 0, mem_io = 0, mem_wmask = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, all done pulses = 0, bus_err = 0, state = IDLE, last = DMA (core wins the first tie).
- Assertion of reset_n low mid-access immediately clears mem_req and returns to IDLE. No done pulse is issued for the aborted access.
- Minimum latency:
  - Request seen in IDLE at cycle 0.
  - mem_req high at cycle 1.
  - mem_ack at cycle 1 gives the done pulse at cycle 2; the arbiter is back in IDLE at cycle 3.
- Each mem_ack cycle beyond cycle 1 adds one cycle of latency.
- mem_ack outside BUSY is ignored.
- Back-to-back with both requesters pending: the core and DMA alternate. Each access takes 3 cycles minimum, with no starvation.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter (width $clog2(TIMEOUT+1)) clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT without mem_ack: drop mem_req, go to DONE, set rdata = 0, and pulse bus_err together with the owner's done pulse.
  - mem_ack in the same cycle the counter reaches TIMEOUT wins, with normal completion and no bus_err.
- `MEM_TIMEOUT_EN` undefined: no counter, BUSY waits indefinitely for mem_ack, bus_err tied to 0.

## Test plan
- Reset, then core read: rstrobe = 2'b01, addr = 0x10, mem_ack at cycle 1, mem_rdata = 0x1234 → mem_req in cycle 1 only with mem_addr = 0x10 and mem_we = 0, rdone and rdata = 0x1234 in cycle 2, no other done pulse.
- Core write: wmask = 2'b10, wdata = 0xAB00, mem_ack delayed 3 cycles → mem_we = 1 and mem_wmask = 2'b10 stable for 4 cycles, then wdone in the cycle after mem_ack.
- ifetch and dma_req raised together, repeated 4 times → grants in the order core, DMA, core, DMA; idone and dma_ack alternate.
- Reset asserted asynchronously while in BUSY → mem_req low without waiting for a clock edge, no done pulse, next request is serviced normally after release.
- With `MEM_TIMEOUT_EN` and TIMEOUT = 4, DMA read with mem_ack never asserted → bus_err and dma_ack together 5 cycles after mem_req rises, rdata = 0.
- With `MEM_TIMEOUT_EN`, mem_ack in the same cycle the counter reaches TIMEOUT → normal completion with mem_rdata, bus_err stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter placing core fetch/read/write and DMA accesses on one req/ack memory port.
// Latency: request in IDLE -> mem_req next cycle -> done pulse the cycle after mem_ack -> back in IDLE.
// Backpressure: requesters hold level until their pulse; optional watchdog abort under MEM_TIMEOUT_EN.
module mem_arbiter #(
   parameter int RV      = 16,   // data width, 16 or 32
   parameter int VA      = RV,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                ifetch,
   input  logic [1:0]          rstrobe,
   input  logic [RV/8-1:0]     wmask,
   input  logic                io_access,
   input  logic [VA-RV/16-1:0] addr,
   input  logic [RV-1:0]       wdata,
   output logic                idone,
   output logic                rdone,
   output logic                wdone,
   output logic [RV-1:0]       rdata,
   input  logic                dma_req,
   input  logic                dma_we,
   input  logic [VA-RV/16-1:0] dma_addr,
   input  logic [RV-1:0]       dma_wdata,
   input  logic [RV/8-1:0]     dma_wmask,
   output logic                dma_ack,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_io,
   output logic [VA-RV/16-1:0] mem_addr,
   output logic [RV-1:0]       mem_wdata,
   output logic [RV/8-1:0]     mem_wmask,
   input  logic                mem_ack,
   input  logic [RV-1:0]       mem_rdata,
   output logic                bus_err
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   typedef enum logic [1:0] {K_FETCH, K_READ, K_WRITE} kind_t;

   state_t state;
   kind_t  kind;
   kind_t  core_kind;
   logic   owner;        // 1 = DMA owns the current access
   logic   last;         // 1 = DMA was granted most recently
   logic   core_pend;
   logic   grant_dma;
   logic   timeout_hit;

   assign core_pend = ifetch | (|rstrobe) | (|wmask);
   // On a tie the requester not served last wins.
   assign grant_dma = dma_req & (~core_pend | ~last);

   always_comb begin
      core_kind = K_WRITE;
      if (ifetch)
         core_kind = K_FETCH;
      else if (|rstrobe)
         core_kind = K_READ;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         kind      <= K_FETCH;
         owner     <= 1'b0;
         last      <= 1'b1;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_io    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         rdata     <= '0;
         idone     <= 1'b0;
         rdone     <= 1'b0;
         wdone     <= 1'b0;
         dma_ack   <= 1'b0;
      end else begin
         idone   <= 1'b0;
         rdone   <= 1'b0;
         wdone   <= 1'b0;
         dma_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (core_pend || dma_req) begin
                  state   <= S_BUSY;
                  mem_req <= 1'b1;
                  owner   <= grant_dma;
                  if (grant_dma) begin
                     kind      <= dma_we ? K_WRITE : K_READ;
                     mem_we    <= dma_we;
                     mem_io    <= 1'b0;
                     mem_addr  <= dma_addr;
                     mem_wdata <= dma_wdata;
                     mem_wmask <= dma_wmask;
                  end else begin
                     kind      <= core_kind;
                     mem_we    <= (core_kind == K_WRITE);
                     mem_io    <= (core_kind == K_FETCH) ? 1'b0 : io_access;
                     mem_addr  <= addr;
                     mem_wdata <= wdata;
                     mem_wmask <= (core_kind == K_WRITE) ? wmask : '0;
                  end
               end
            end
            S_BUSY: begin
               if (mem_ack || timeout_hit) begin
                  state   <= S_DONE;
                  mem_req <= 1'b0;
                  idone   <= !owner && (kind == K_FETCH);
                  rdone   <= !owner && (kind == K_READ);
                  wdone   <= !owner && (kind == K_WRITE);
                  dma_ack <= owner;
                  // An ack coinciding with the watchdog limit still completes normally.
                  if (!mem_ack)
                     rdata <= '0;
                  else if (kind != K_WRITE)
                     rdata <= mem_rdata;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               last  <= owner;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CW-1:0] cnt;

   assign timeout_hit = (cnt == CW'(TIMEOUT));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= (state == S_BUSY) && timeout_hit && !mem_ack;
         if (state == S_BUSY)
            cnt <= cnt + CW'(1);
         else
            cnt <= '0;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign timeout_hit    = 1'b0;
   assign bus_err        = 1'b0;
`endif

endmodule
